// File: rtl/odd_issue.sv
// Odd-pipe issue stage: 2-entry instruction queue, operand read, RAW-gated issue to Permute.
// Optional writeback bypass mux enabled by defining ODD_ISSUE_BYPASS_EN (default: stall instead).
module odd_issue #(
    parameter int DEPTH       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [0:10]              in_op,
    input  logic [0:2]               in_format,
    input  logic [0:6]               in_rt_addr,
    input  logic [0:6]               in_ra_addr,
    input  logic [0:6]               in_rb_addr,
    input  logic                     in_ra_used,
    input  logic                     in_rb_used,
    input  logic [0:17]              in_imm,
    input  logic                     in_reg_write,
    output logic [0:6]               rf_ra_addr,
    output logic [0:6]               rf_rb_addr,
    input  logic [0:127]             rf_ra_data,
    input  logic [0:127]             rf_rb_data,
    output logic [0:7]               ra_odd_addr,
    output logic [0:7]               rb_odd_addr,
    input  logic                     stall_odd_raw,
    input  logic [0:127]             rt_wb,
    input  logic [0:6]               rt_addr_wb,
    input  logic                     reg_write_wb,
    input  logic                     branch_taken,
    output logic [0:10]              op,
    output logic [0:2]               format,
    output logic [0:6]               rt_addr,
    output logic [0:127]             ra,
    output logic [0:127]             rb,
    output logic [0:17]              imm,
    output logic                     reg_write,
    output logic [0:STALL_CNT_W-1]   stall_count
);

    typedef struct packed {
        logic [0:10] op;
        logic [0:2]  format;
        logic [0:6]  rt;
        logic [0:6]  ra;
        logic [0:6]  rb;
        logic        ra_used;
        logic        rb_used;
        logic [0:17] imm;
        logic        reg_write;
    } entry_t;

    entry_t       mem [DEPTH];
    entry_t       head;
    entry_t       in_entry;
    logic         head_ptr;
    logic         tail_ptr;
    logic [1:0]   count;
    logic         head_valid;
    logic         ra_hit;
    logic         rb_hit;
    logic         bypass_stall;
    logic [0:127] ra_sel;
    logic [0:127] rb_sel;
    logic         issue;
    logic         push;

    assign head       = mem[head_ptr];
    assign head_valid = (count != 2'd0);
    assign in_ready   = (count != DEPTH[1:0]);
    assign push       = in_valid && in_ready && !branch_taken;

    assign in_entry = '{op: in_op, format: in_format, rt: in_rt_addr, ra: in_ra_addr,
                        rb: in_rb_addr, ra_used: in_ra_used, rb_used: in_rb_used,
                        imm: in_imm, reg_write: in_reg_write};

    assign rf_ra_addr  = head.ra;
    assign rf_rb_addr  = head.rb;
    // Empty queue also presents the never-matching address so Permute sees no hazard.
    assign ra_odd_addr = (head_valid && head.ra_used) ? {1'b0, head.ra} : 8'hFF;
    assign rb_odd_addr = (head_valid && head.rb_used) ? {1'b0, head.rb} : 8'hFF;

    assign ra_hit = reg_write_wb && (rt_addr_wb == head.ra);
    assign rb_hit = reg_write_wb && (rt_addr_wb == head.rb);

`ifdef ODD_ISSUE_BYPASS_EN
    assign bypass_stall = 1'b0;
    assign ra_sel       = ra_hit ? rt_wb : rf_ra_data;
    assign rb_sel       = rb_hit ? rt_wb : rf_rb_data;
`else
    logic unused_wb;
    assign unused_wb    = ^rt_wb;
    assign bypass_stall = head_valid && ((head.ra_used && ra_hit) || (head.rb_used && rb_hit));
    assign ra_sel       = rf_ra_data;
    assign rb_sel       = rf_rb_data;
`endif

    assign issue = head_valid && !stall_odd_raw && !branch_taken && !bypass_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            head_ptr    <= 1'b0;
            tail_ptr    <= 1'b0;
            count       <= 2'd0;
            op          <= '0;
            format      <= '0;
            rt_addr     <= '0;
            ra          <= '0;
            rb          <= '0;
            imm         <= '0;
            reg_write   <= 1'b0;
            stall_count <= '0;
        end else begin
            if (branch_taken) begin
                head_ptr <= 1'b0;
                tail_ptr <= 1'b0;
                count    <= 2'd0;
            end else begin
                if (push) begin
                    mem[tail_ptr] <= in_entry;
                    tail_ptr      <= ~tail_ptr;
                end
                if (issue) head_ptr <= ~head_ptr;
                case ({push, issue})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end

            if (issue) begin
                op        <= head.op;
                format    <= head.format;
                rt_addr   <= head.rt;
                ra        <= ra_sel;
                rb        <= rb_sel;
                imm       <= head.imm;
                reg_write <= head.reg_write;
            end else begin
                op        <= '0;
                format    <= '0;
                rt_addr   <= '0;
                ra        <= '0;
                rb        <= '0;
                imm       <= '0;
                reg_write <= 1'b0;
            end

            if (head_valid && !branch_taken && !issue && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_odd_issue.sv
// Directed self-checking bench for odd_issue; expectations follow ODD_ISSUE_BYPASS_EN when defined.
module tb_odd_issue;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [0:10]   in_op;
    logic [0:2]    in_format;
    logic [0:6]    in_rt_addr, in_ra_addr, in_rb_addr;
    logic          in_ra_used, in_rb_used;
    logic [0:17]   in_imm;
    logic          in_reg_write;
    logic [0:6]    rf_ra_addr, rf_rb_addr;
    logic [0:127]  rf_ra_data, rf_rb_data;
    logic [0:7]    ra_odd_addr, rb_odd_addr;
    logic          stall_odd_raw;
    logic [0:127]  rt_wb;
    logic [0:6]    rt_addr_wb;
    logic          reg_write_wb;
    logic          branch_taken;
    logic [0:10]   op;
    logic [0:2]    format;
    logic [0:6]    rt_addr;
    logic [0:127]  ra, rb;
    logic [0:17]   imm;
    logic          reg_write;
    logic [0:15]   stall_count;

    logic          stall_force;
    logic          hazard_en;
    int            tests_run = 0;
    int            tests_failed = 0;

    localparam logic [0:10]  OP_ROTQBI = 11'b00111011000;
    localparam logic [0:10]  OP_GBB    = 11'b00110110000;
    localparam logic [0:127] RF_A      = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [0:127] WB_A      = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;

    // Permute hazard model: a forced stall, or an in-flight rt of 5.
    assign stall_odd_raw = stall_force ||
                           (hazard_en && (ra_odd_addr == 8'h05 || rb_odd_addr == 8'h05));

    odd_issue #(.DEPTH(2), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_format(in_format), .in_rt_addr(in_rt_addr),
        .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
        .in_ra_used(in_ra_used), .in_rb_used(in_rb_used), .in_imm(in_imm),
        .in_reg_write(in_reg_write), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
        .ra_odd_addr(ra_odd_addr), .rb_odd_addr(rb_odd_addr),
        .stall_odd_raw(stall_odd_raw), .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb),
        .reg_write_wb(reg_write_wb), .branch_taken(branch_taken),
        .op(op), .format(format), .rt_addr(rt_addr), .ra(ra), .rb(rb), .imm(imm),
        .reg_write(reg_write), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_op = '0; in_format = '0; in_rt_addr = '0; in_ra_addr = '0;
        in_rb_addr = '0; in_ra_used = 0; in_rb_used = 0; in_imm = '0; in_reg_write = 0;
        rf_ra_data = '0; rf_rb_data = '0; rt_wb = '0; rt_addr_wb = '0; reg_write_wb = 0;
        branch_taken = 0; stall_force = 0; hazard_en = 0;
    endtask

    task automatic set_in(input logic [0:10] o, input logic [0:6] rt, input logic [0:6] a,
                          input logic [0:6] b, input logic au, input logic bu,
                          input logic [0:17] im);
        in_valid = 1; in_op = o; in_format = 3'd0; in_rt_addr = rt; in_ra_addr = a;
        in_rb_addr = b; in_ra_used = au; in_rb_used = bu; in_imm = im; in_reg_write = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (5) tick();
        tests_run++; if (op !== 11'd0 || rt_addr !== 7'd0 || reg_write !== 1'b0) begin
            tests_failed++; $display("FAIL reset_nop op=%h rt=%h rw=%b want 0", op, rt_addr, reg_write); end
        tests_run++; if (ra !== 128'd0 || rb !== 128'd0 || imm !== 18'd0 || format !== 3'd0) begin
            tests_failed++; $display("FAIL reset_data ra=%h rb=%h want 0", ra, rb); end
        tests_run++; if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready got %b want 1", in_ready); end
        tests_run++; if (stall_count !== 16'd0) begin
            tests_failed++; $display("FAIL reset_stall_count got %0d want 0", stall_count); end
        tests_run++; if (ra_odd_addr !== 8'hFF || rb_odd_addr !== 8'hFF) begin
            tests_failed++; $display("FAIL reset_odd_addr got %h/%h want ff/ff", ra_odd_addr, rb_odd_addr); end
    endtask

    task automatic test_single_issue();
        do_reset();
        rf_ra_data = RF_A;
        rf_rb_data = 128'd3;
        set_in(OP_ROTQBI, 7'd5, 7'd3, 7'd4, 1, 1, 18'h00012);
        tick();
        in_valid = 0;
        tests_run++; if (op !== 11'd0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL single_head_cycle op=%h ready=%b want 0/1", op, in_ready); end
        tests_run++; if (ra_odd_addr !== 8'h03 || rb_odd_addr !== 8'h04 || rf_ra_addr !== 7'd3 || rf_rb_addr !== 7'd4) begin
            tests_failed++; $display("FAIL single_addr odd=%h/%h rf=%h/%h want 03/04 3/4",
                                     ra_odd_addr, rb_odd_addr, rf_ra_addr, rf_rb_addr); end
        tick();
        tests_run++; if (op !== OP_ROTQBI || rt_addr !== 7'd5 || reg_write !== 1'b1 || imm !== 18'h00012) begin
            tests_failed++; $display("FAIL single_issue op=%h rt=%h rw=%b imm=%h want %h/5/1/12",
                                     op, rt_addr, reg_write, imm, OP_ROTQBI); end
        tests_run++; if (ra !== RF_A || rb !== 128'd3) begin
            tests_failed++; $display("FAIL single_operands ra=%h rb=%h want %h/3", ra, rb, RF_A); end
        tick();
        tests_run++; if (op !== 11'd0 || reg_write !== 1'b0 || stall_count !== 16'd0) begin
            tests_failed++; $display("FAIL single_after op=%h rw=%b sc=%0d want 0/0/0", op, reg_write, stall_count); end
    endtask

    task automatic test_stall();
        do_reset();
        rf_ra_data = 128'h1111;
        rf_rb_data = 128'h2222;
        stall_force = 1;
        set_in(11'd1, 7'd10, 7'd1, 7'd2, 1, 1, 18'd0);
        tick();
        set_in(11'd2, 7'd11, 7'd1, 7'd2, 1, 1, 18'd0);
        tick();
        in_valid = 0;
        tests_run++; if (in_ready !== 1'b0 || op !== 11'd0) begin
            tests_failed++; $display("FAIL stall_full ready=%b op=%h want 0/0", in_ready, op); end
        tick();
        tick();
        tests_run++; if (stall_count !== 16'd3 || op !== 11'd0 || in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL stall_count got sc=%0d op=%h ready=%b want 3/0/0",
                                     stall_count, op, in_ready); end
        stall_force = 0;
        tick();
        tests_run++; if (op !== 11'd1 || rt_addr !== 7'd10 || ra !== 128'h1111 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL stall_first op=%h rt=%h ready=%b want 1/a/1", op, rt_addr, in_ready); end
        tick();
        tests_run++; if (op !== 11'd2 || rt_addr !== 7'd11 || rb !== 128'h2222) begin
            tests_failed++; $display("FAIL stall_second op=%h rt=%h want 2/b", op, rt_addr); end
        tick();
        tests_run++; if (op !== 11'd0 || stall_count !== 16'd3) begin
            tests_failed++; $display("FAIL stall_drained op=%h sc=%0d want 0/3", op, stall_count); end
    endtask

    task automatic test_bypass();
        do_reset();
        rf_ra_data = RF_A;
        rf_rb_data = 128'h5555;
        set_in(11'd3, 7'd7, 7'd3, 7'd9, 1, 1, 18'd0);
        tick();
        in_valid = 0;
        reg_write_wb = 1; rt_addr_wb = 7'd3; rt_wb = WB_A; rf_ra_data = '0;
        tick();
`ifdef ODD_ISSUE_BYPASS_EN
        reg_write_wb = 0;
        tests_run++; if (op !== 11'd3 || ra !== WB_A || rb !== 128'h5555) begin
            tests_failed++; $display("FAIL bypass_issue op=%h ra=%h rb=%h want 3/%h/5555", op, ra, rb, WB_A); end
        tests_run++; if (stall_count !== 16'd0) begin
            tests_failed++; $display("FAIL bypass_sc got %0d want 0", stall_count); end
`else
        tests_run++; if (op !== 11'd0 || stall_count !== 16'd1) begin
            tests_failed++; $display("FAIL bypass_wait op=%h sc=%0d want 0/1", op, stall_count); end
        reg_write_wb = 0;
        tick();
        tests_run++; if (op !== 11'd3 || ra !== 128'd0 || rb !== 128'h5555 || stall_count !== 16'd1) begin
            tests_failed++; $display("FAIL bypass_late op=%h ra=%h sc=%0d want 3/0/1", op, ra, stall_count); end
`endif
        tick();
        tests_run++; if (op !== 11'd0) begin
            tests_failed++; $display("FAIL bypass_after op=%h want 0", op); end
    endtask

    task automatic test_flush();
        do_reset();
        stall_force = 1;
        set_in(11'd4, 7'd12, 7'd1, 7'd2, 1, 1, 18'd0);
        tick();
        set_in(11'd5, 7'd13, 7'd1, 7'd2, 1, 1, 18'd0);
        tick();
        set_in(11'd6, 7'd14, 7'd1, 7'd2, 1, 1, 18'd0);
        branch_taken = 1;
        tick();
        in_valid = 0; branch_taken = 0; stall_force = 0;
        tests_run++; if (in_ready !== 1'b1 || ra_odd_addr !== 8'hFF || op !== 11'd0) begin
            tests_failed++; $display("FAIL flush_empty ready=%b odd=%h op=%h want 1/ff/0", in_ready, ra_odd_addr, op); end
        tests_run++; if (stall_count !== 16'd1) begin
            tests_failed++; $display("FAIL flush_sc got %0d want 1", stall_count); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (op !== 11'd0 || reg_write !== 1'b0) begin
                tests_failed++; $display("FAIL flush_no_issue cycle %0d op=%h want 0", i, op); end
        end
    endtask

    task automatic test_gbb();
        do_reset();
        hazard_en = 1;
        rf_ra_data = 128'h77;
        rf_rb_data = 128'h88;
        set_in(OP_GBB, 7'd9, 7'd8, 7'd5, 1, 0, 18'd0);
        tick();
        in_valid = 0;
        tests_run++; if (rb_odd_addr !== 8'hFF || ra_odd_addr !== 8'h08) begin
            tests_failed++; $display("FAIL gbb_addr odd=%h/%h want 08/ff", ra_odd_addr, rb_odd_addr); end
        tick();
        tests_run++; if (op !== OP_GBB || rt_addr !== 7'd9 || ra !== 128'h77 || stall_count !== 16'd0) begin
            tests_failed++; $display("FAIL gbb_issue op=%h rt=%h sc=%0d want %h/9/0", op, rt_addr, stall_count, OP_GBB); end
        hazard_en = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_in(11'h10, 7'd1, 7'd20, 7'd21, 1, 1, 18'd0);
        tick();
        set_in(11'h11, 7'd2, 7'd22, 7'd23, 1, 1, 18'd0);
        tick();
        in_valid = 0;
        tests_run++; if (op !== 11'h10 || in_ready !== 1'b1 || ra_odd_addr !== 8'd22) begin
            tests_failed++; $display("FAIL b2b_first op=%h ready=%b odd=%h want 10/1/16", op, in_ready, ra_odd_addr); end
        tick();
        tests_run++; if (op !== 11'h11 || rt_addr !== 7'd2) begin
            tests_failed++; $display("FAIL b2b_second op=%h rt=%h want 11/2", op, rt_addr); end
        tick();
        tests_run++; if (op !== 11'd0 || stall_count !== 16'd0) begin
            tests_failed++; $display("FAIL b2b_after op=%h sc=%0d want 0/0", op, stall_count); end
    endtask

    task automatic test_midreset();
        do_reset();
        stall_force = 1;
        set_in(11'd7, 7'd3, 7'd1, 7'd2, 1, 1, 18'd0);
        tick();
        in_valid = 0;
        tick();
        tick();
        reset = 1; branch_taken = 1;
        set_in(11'd8, 7'd4, 7'd1, 7'd2, 1, 1, 18'd0);
        tick();
        reset = 0; branch_taken = 0; in_valid = 0; stall_force = 0;
        tests_run++; if (stall_count !== 16'd0 || in_ready !== 1'b1 || ra_odd_addr !== 8'hFF || op !== 11'd0) begin
            tests_failed++; $display("FAIL midreset_state sc=%0d ready=%b odd=%h op=%h want 0/1/ff/0",
                                     stall_count, in_ready, ra_odd_addr, op); end
        tick();
        tests_run++; if (op !== 11'd0) begin
            tests_failed++; $display("FAIL midreset_no_issue op=%h want 0", op); end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_single_issue();
        test_stall();
        test_bypass();
        test_flush();
        test_gbb();
        test_back_to_back();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
